mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter that shares the core's single memory/cache port between the instruction-fetch stage and the load/store stage. It serialises requests, sequences each memory transaction, and routes the response back to the owner. It produces the fetch-side stall and discards fetch responses cancelled by a branch flush. It sits between the pipeline front/back ends and the cache interface.

## Interface
Parameters:
- DATA_WIDTH, 32 (`DATA_WIDTH`), address and data width.
- STARVE_LIMIT, 4: maximum consecutive data grants while fetch is waiting.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_valid or if_flush.
- if_addr  in  DATA_WIDTH  fetch PC.
- if_flush  in  1  branch redirect; cancels any fetch in flight.
- if_valid  out  1  fetch response, 1-cycle pulse.
- if_data  out  DATA_WIDTH  instruction word; valid with if_valid.
- if_stall  out  1  = if_req & ~if_valid.
- d_req  in  1  load/store request; held until d_ready.
- d_we  in  1  1 = store.
- d_addr  in  DATA_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_wstrb  in  4  byte enables.
- d_ready  out  1  data response/ack, 1-cycle pulse.
- d_rdata  out  DATA_WIDTH  load data.
- d_busy  out  1  = d_req & ~d_ready.
- mem_req  out  1  registered; held until mem_gnt.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/DATA_WIDTH/DATA_WIDTH/4  registered command; fetch uses mem_we=0, mem_wstrb=4'b0000.
- mem_gnt  in  1  command accepted.
- mem_rvalid  in  1  read data or write ack.
- mem_rdata  in  DATA_WIDTH  read data.

## Operation
- States: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D. At most one transaction is outstanding.
- IDLE: pick a winner and latch its command into the mem_* registers.
  - Move to REQ_x and drive mem_req=1.
  - No requester present: stay in IDLE.
- REQ_x: hold mem_req and the command until mem_gnt. On mem_gnt, go to WAIT_x and drop mem_req. mem_req is never withdrawn early.
- WAIT_x: wait for mem_rvalid.
  - Pass mem_rdata combinationally to if_data/d_rdata.
  - Pulse if_valid or d_ready for one cycle.
  - Return to IDLE.
- Arbitration:
  - Data has priority.
  - starve_cnt counts consecutive data grants made while if_req=1.
  - When starve_cnt == STARVE_LIMIT and both requesters are pending, fetch wins.
  - starve_cnt clears on any fetch grant, or whenever if_req=0 in IDLE.
  - starve_cnt saturates at STARVE_LIMIT.
- Flush:
  - if_flush in REQ_I or WAIT_I sets drop. The transaction still completes on the memory side, but the response is consumed with if_valid=0. drop clears on leaving WAIT_I.
  - if_flush in the same cycle as mem_rvalid in WAIT_I suppresses if_valid.
  - if_flush in IDLE, REQ_D or WAIT_D has no effect.
  - A fetch request presented in the flush cycle is not arbitrated until the next cycle. This guarantees the new PC is sampled.
- if_data/d_rdata outside their valid pulse: drive mem_rdata; the value is don't-care.

## Timing
- Reset (reset=0 at a clock edge) gives:
  - state IDLE; mem_req=0; mem_we=0; mem_addr, mem_wdata and mem_wstrb all 0;
  - drop=0; starve_cnt=0;
  - if_valid=0 and d_ready=0.
- Reset mid-transaction abandons the transaction. The memory side is reset by the same reset.
- Cycle 0: request seen in IDLE. Cycle 1: mem_req=1.
- With mem_gnt in cycle 1 and mem_rvalid in cycle 2, the response pulse is in cycle 2 and the block is back in IDLE in cycle 3.
- Minimum spacing: 3 cycles per access. Each cycle of gnt/rvalid delay adds one cycle.
- mem_rvalid outside WAIT_x is ignored.

## Structure
- Shared header sabit_veriler.vh holds:
  - `DATA_WIDTH` and `FIRST_ADDR` (existing);
  - new `ARB_IDLE`, `ARB_REQ_I`, `ARB_REQ_D`, `ARB_WAIT_I`, `ARB_WAIT_D` as 3-bit state encodings;
  - `ARB_STARVE_LIMIT` as the default.
- One sub-module, arb_starve_counter: saturating counter with clear, increment and limit-reached outputs.
- The FSM and command registers stay in the top module.

## Test plan
- Fetch only: if_addr=0x0000_0100, mem_gnt in the request cycle, mem_rvalid next cycle with 0x0010_0093 → if_valid in cycle 2 with if_data=0x0010_0093; if_stall=1 in cycles 0–1.
- Simultaneous if_req and d_req (store 0xDEAD_BEEF to 0x200, wstrb=4'hF) → data is issued first with mem_we=1; fetch is issued afterwards; d_ready precedes if_valid.
- d_req held continuously, if_req pending, STARVE_LIMIT=4 → exactly 4 data grants, then one fetch grant, then data resumes.
- if_flush asserted in WAIT_I with mem_rvalid delayed 3 cycles → no if_valid pulse; the next fetch to 0x300 returns its own data.
- mem_gnt held low for 5 cycles → mem_req and mem_addr stay stable throughout; then normal completion.
- reset=0 asserted in WAIT_D → next cycle: mem_req=0, d_ready=0, state IDLE; a later mem_rvalid is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - types and defaults for the shared memory-port arbiter
package mem_port_arbiter_pkg;
`include "sabit_veriler.vh"

    localparam int ARB_DW        = `DATA_WIDTH;
    localparam int ARB_LIMIT_DEF = `ARB_STARVE_LIMIT;

    typedef enum logic [2:0] {
        ST_IDLE   = `ARB_IDLE,
        ST_REQ_I  = `ARB_REQ_I,
        ST_REQ_D  = `ARB_REQ_D,
        ST_WAIT_I = `ARB_WAIT_I,
        ST_WAIT_D = `ARB_WAIT_D
    } arb_state_e;

    // Bits needed to hold a count from 0 up to and including limit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and cache-port signal bundle
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = ARB_DW
);
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_data;
    logic                  if_stall;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [3:0]            d_wstrb;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_busy;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_valid, if_data, if_stall, d_ready, d_rdata, d_busy,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_wstrb,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_valid, if_data, if_stall, d_ready, d_rdata, d_busy,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating count of data grants made while fetch waits
module arb_starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_limit = (cnt_q == W'(LIMIT));

    // Clear wins over increment; the count parks at LIMIT instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sabit_veriler.vh
// rtl/sabit_veriler.vh - shared core constants and memory-port arbiter state encodings
`ifndef SABIT_VERILER_VH
`define SABIT_VERILER_VH

`define DATA_WIDTH       32
`define FIRST_ADDR       32'h0000_0000

`define ARB_IDLE         3'd0
`define ARB_REQ_I        3'd1
`define ARB_REQ_D        3'd2
`define ARB_WAIT_I       3'd3
`define ARB_WAIT_D       3'd4

`define ARB_STARVE_LIMIT 4

`endif

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = ARB_DW,
    parameter int STARVE_LIMIT = ARB_LIMIT_DEF
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = cnt_width(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;

    logic                  if_valid;
    logic                  d_ready;
    logic                  i_pend;
    logic                  grant_i;
    logic                  grant_d;
    logic                  starve_clr;
    logic                  starve_inc;
    logic                  starve_at_limit;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CW)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .clr      (starve_clr),
        .inc      (starve_inc),
        .at_limit (starve_at_limit)
    );

    // Winner selection in IDLE: data first unless fetch has waited out the starve limit.
    // A fetch arriving together with a flush is held off one cycle so the new PC is used.
    always_comb begin
        i_pend  = bus.if_req & ~bus.if_flush;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_pend && (!bus.d_req || starve_at_limit)) begin
                grant_i = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end
        end
        starve_clr = grant_i | ((state_q == ST_IDLE) & ~bus.if_req);
        starve_inc = grant_d & bus.if_req;
    end

    // Transaction sequencer: latch command, hold until grant, wait for response, route it.
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_valid    = 1'b0;
        d_ready     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (grant_i) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = 4'b0000;
                    state_d     = ST_REQ_I;
                end else if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_wstrb;
                    state_d     = ST_REQ_D;
                end
            end
            ST_REQ_I: begin
                if (bus.if_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT_I;
                end
            end
            ST_REQ_D: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT_D;
                end
            end
            ST_WAIT_I: begin
                if (bus.mem_rvalid) begin
                    if_valid = ~drop_q & ~bus.if_flush;
                    drop_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (bus.if_flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_WAIT_D: begin
                if (bus.mem_rvalid) begin
                    d_ready = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    // State and command registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign bus.if_valid  = if_valid;
    assign bus.if_data   = bus.mem_rdata;
    assign bus.if_stall  = bus.if_req & ~if_valid;
    assign bus.d_ready   = d_ready;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.d_busy    = bus.d_req & ~d_ready;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
endmodule
